// File: rtl/simon_player_input.sv
// Simon player front end: syncs and debounces buttons, strobes accepted presses, drives LEDs.
// Latency: press stable before edge N -> playerPressed high after edge N+1+DEBOUNCE_CYCLES.
// Backpressure: none; the strobe is fire-and-forget. Holding a button never re-strobes.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   btn[3:0]          raw active-high buttons, btn[i] selects number i
//   simonTurn         1 = controller is playing back, 0 = player's turn
//   simonNum/simonPressed  controller playback number and its "lit" phase
//   gameOver          game ended; all LEDs flash
//   playerNum         encoded accepted button, held until the next accept
//   playerPressed     one-cycle strobe qualifying playerNum
//   led[3:0]          registered LED drive
//   timeout           one-cycle inactivity strobe
// Optional feature: define SIMON_TIMEOUT_EN to build the idle timeout counter;
// otherwise timeout is tied low.
module simon_player_input #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int BLINK_CYCLES    = 30,
    parameter int TIMEOUT_CYCLES  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic [1:0] simonNum,
    input  logic       simonPressed,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic [3:0] led,
    output logic       timeout
);

    if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("simon_player_input: cycle parameters must be >= 1");
    end

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [CNT_W:0]   DEB_L      = (CNT_W + 1)'(DEBOUNCE_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST_L = BLK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, LOCKOUT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync_q, bs_q;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       player_num_q, player_num_d;
    logic             player_pressed_q, player_pressed_d;
    logic [3:0]       led_q, led_d;
    logic [BLK_W-1:0] blink_cnt_q;
    logic             blink_off_q;
    logic             accept;
    logic             active;
    logic             bs_onehot;
    logic [1:0]       bs_idx;

    assign active    = !simonTurn && !gameOver;
    // Power-of-two test: exactly one bit set.
    assign bs_onehot = (bs_q != 4'd0) && ((bs_q & (bs_q - 4'd1)) == 4'd0);

    always_comb begin
        bs_idx = 2'd0;
        case (bs_q)
            4'b0010: bs_idx = 2'd1;
            4'b0100: bs_idx = 2'd2;
            4'b1000: bs_idx = 2'd3;
            default: bs_idx = 2'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including candidate latch and debounce count
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bs_q != 4'd0) begin
                    if (active && bs_onehot) begin
                        cand_d  = bs_idx;
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end
            end
            DEBOUNCE: begin
                // active is checked here too, so a turn change on the completing
                // edge aborts the press rather than strobing it.
                if (active && bs_q == (4'b0001 << cand_q)) begin
                    if (({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= DEB_L) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = LOCKOUT;
                end
            end
            HELD, LOCKOUT: begin
                if (bs_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic (registered below)
    always_comb begin
        player_pressed_d = accept;
        player_num_d     = accept ? cand_q : player_num_q;
        if (gameOver) begin
            led_d = blink_off_q ? 4'h0 : 4'hF;
        end else if (simonTurn) begin
            led_d = simonPressed ? (4'b0001 << simonNum) : 4'h0;
        end else if (state_q == HELD) begin
            led_d = 4'b0001 << player_num_q;
        end else begin
            led_d = 4'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q           <= 4'h0;
            bs_q             <= 4'h0;
            cand_q           <= 2'd0;
            cnt_q            <= '0;
            player_num_q     <= 2'd0;
            player_pressed_q <= 1'b0;
            led_q            <= 4'h0;
            blink_cnt_q      <= '0;
            blink_off_q      <= 1'b0;
        end else begin
            sync_q           <= btn;
            bs_q             <= sync_q;
            cand_q           <= cand_d;
            cnt_q            <= cnt_d;
            player_num_q     <= player_num_d;
            player_pressed_q <= player_pressed_d;
            led_q            <= led_d;
            // Blink phase restarts "lit" every time gameOver drops.
            if (!gameOver) begin
                blink_cnt_q <= '0;
                blink_off_q <= 1'b0;
            end else if (blink_cnt_q == BLK_LAST_L) begin
                blink_cnt_q <= '0;
                blink_off_q <= ~blink_off_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            end
        end
    end

    assign playerNum     = player_num_q;
    assign playerPressed = player_pressed_q;
    assign led           = led_q;

`ifdef SIMON_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST_L = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt_q;
    logic            timeout_q;

    // Counts only while the player could press but is sitting idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (active && state_q == IDLE) begin
            if (idle_cnt_q == TO_LAST_L) begin
                idle_cnt_q <= '0;
                timeout_q  <= 1'b1;
            end else begin
                idle_cnt_q <= idle_cnt_q + TO_W'(1);
                timeout_q  <= 1'b0;
            end
        end else begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_simon_player_input.sv
module tb_simon_player_input;

    localparam int DEB = 3;
    localparam int BLK = 30;
    localparam int TO  = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       simonTurn;
    logic [1:0] simonNum;
    logic       simonPressed;
    logic       gameOver;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic [3:0] led;
    logic       timeout;

    simon_player_input #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .simonTurn    (simonTurn),
        .simonNum     (simonNum),
        .simonPressed (simonPressed),
        .gameOver     (gameOver),
        .playerNum    (playerNum),
        .playerPressed(playerPressed),
        .led          (led),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Press tracking is described by "how many consecutive matching samples so far"
    // plus two flags for "waiting for all buttons released" (after an accept or a reject).
    logic [3:0] m_s1, m_bs;
    int         m_run;
    logic [1:0] m_cand, m_num;
    logic       m_held, m_lock;
    int         m_bc;
    logic       m_on;
    int         m_idle;
    logic       e_pp, e_to;
    logic [1:0] e_num;
    logic [3:0] e_led;

    function automatic void model_reset();
        m_s1 = 0; m_bs = 0; m_run = 0; m_cand = 0; m_num = 0;
        m_held = 0; m_lock = 0; m_bc = 0; m_on = 1; m_idle = 0;
        e_pp = 0; e_to = 0; e_num = 0; e_led = 0;
    endfunction

    function automatic void model_step();
        logic act, idle;
        if (reset) begin
            model_reset();
            return;
        end
        act  = !simonTurn && !gameOver;
        idle = !m_held && !m_lock && (m_run == 0);
        // LEDs from pre-edge view
        if (gameOver)       e_led = m_on ? 4'hF : 4'h0;
        else if (simonTurn) e_led = simonPressed ? (4'b0001 << simonNum) : 4'h0;
        else if (m_held)    e_led = 4'b0001 << m_num;
        else                e_led = 4'h0;
        if (!gameOver) begin
            m_bc = 0; m_on = 1;
        end else if (m_bc == BLK - 1) begin
            m_bc = 0; m_on = !m_on;
        end else begin
            m_bc++;
        end
        e_to = 0;
`ifdef SIMON_TIMEOUT_EN
        if (act && idle) begin
            if (m_idle == TO - 1) begin
                m_idle = 0; e_to = 1;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
`endif
        e_pp = 0;
        if (m_held || m_lock) begin
            if (m_bs == 0) begin m_held = 0; m_lock = 0; end
        end else if (m_run == 0) begin
            if (m_bs != 0) begin
                if (act && $countones(m_bs) == 1) begin
                    for (int i = 0; i < 4; i++) if (m_bs[i]) m_cand = 2'(i);
                    m_run = 1;
                end else begin
                    m_lock = 1;
                end
            end
        end else begin
            if (act && m_bs == (4'b0001 << m_cand)) begin
                if (m_run + 1 >= DEB) begin
                    e_pp = 1; m_num = m_cand; m_held = 1; m_run = 0;
                end else begin
                    m_run++;
                end
            end else begin
                m_lock = 1; m_run = 0;
            end
        end
        e_num = m_num;
        m_bs = m_s1;
        m_s1 = btn;
    endfunction

    // ---------------- stepping ----------------
    int cyc, n_strobe, strobe_cyc, n_to, to_first, to_second;

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("playerPressed", 32'(playerPressed), 32'(e_pp));
        chk("playerNum", 32'(playerNum), 32'(e_num));
        chk("led", 32'(led), 32'(e_led));
        chk("timeout", 32'(timeout), 32'(e_to));
        if (playerPressed) begin n_strobe++; strobe_cyc = cyc; end
        if (timeout) begin
            n_to++;
            if (to_first == 0) to_first = cyc;
            else if (to_second == 0) to_second = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic mark();
        cyc = 0; n_strobe = 0; strobe_cyc = -1; n_to = 0; to_first = 0; to_second = 0;
    endtask

    initial begin
        reset = 1; btn = 0; simonTurn = 1; simonNum = 0; simonPressed = 0; gameOver = 0;
        model_reset();
        mark();
        run(2);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_pp", 32'(playerPressed), 32'h0);
        chk("reset_num", 32'(playerNum), 32'h0);
        reset = 0;
        simonTurn = 0;
        run(3);

        // Clean press of button 2
        mark();
        btn = 4'b0100;
        run(10);
        chk("t1_strobe_cycle", 32'(strobe_cyc), 32'd5);
        chk("t1_strobe_count", 32'(n_strobe), 32'd1);
        chk("t1_num", 32'(playerNum), 32'd2);
        chk("t1_led_held", 32'(led), 32'b0100);
        btn = 0;
        run(6);
        chk("t1_led_released", 32'(led), 32'h0);
        chk("t1_no_repeat", 32'(n_strobe), 32'd1);

        // Bounce on button 1
        mark();
        for (int k = 1; k <= 12; k++) begin
            btn = (k == 2 || k == 4) ? 4'b0000 : 4'b0010;
            step();
        end
        chk("t2_strobe_cycle", 32'(strobe_cyc), 32'd9);
        chk("t2_strobe_count", 32'(n_strobe), 32'd1);
        chk("t2_num", 32'(playerNum), 32'd1);
        btn = 0;
        run(6);

        // Rejected presses, then a valid one
        mark();
        btn = 4'b0011;
        run(10);
        btn = 0;
        run(5);
        simonTurn = 1;
        btn = 4'b0001;
        run(8);
        btn = 0;
        run(5);
        chk("t3_no_strobe", 32'(n_strobe), 32'd0);
        simonTurn = 0;
        run(2);
        btn = 4'b1000;
        run(8);
        chk("t3_strobe_count", 32'(n_strobe), 32'd1);
        chk("t3_num", 32'(playerNum), 32'd3);
        btn = 0;
        run(5);

        // Playback LEDs and game-over flash
        simonTurn = 1;
        simonNum = 3;
        for (int k = 0; k < 8; k++) begin
            simonPressed = k[0];
            step();
            chk("t4_playback_led", 32'(led), k[0] ? 32'b1000 : 32'h0);
        end
        mark();
        gameOver = 1;
        run(1);
        chk("t4_blink_first", 32'(led), 32'hF);
        run(29);
        chk("t4_blink_c30", 32'(led), 32'hF);
        run(1);
        chk("t4_blink_c31", 32'(led), 32'h0);
        run(29);
        chk("t4_blink_c60", 32'(led), 32'h0);
        run(1);
        chk("t4_blink_c61", 32'(led), 32'hF);
        gameOver = 0;
        simonTurn = 0;
        simonPressed = 0;
        run(3);

`ifdef SIMON_TIMEOUT_EN
        simonTurn = 1;
        step();
        simonTurn = 0;
        mark();
        run(610);
        chk("t5_timeout_first", 32'(to_first), 32'd300);
        chk("t5_timeout_second", 32'(to_second), 32'd600);
        simonTurn = 1;
        step();
        simonTurn = 0;
        mark();
        run(199);
        btn = 4'b0001;
        run(8);
        btn = 0;
        run(113);
        chk("t5_press_clears", 32'(n_to), 32'd0);
`endif

        // Reset in the middle of a debounce
        btn = 4'b0100;
        run(3);
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("t6_led_async", 32'(led), 32'h0);
        chk("t6_pp_async", 32'(playerPressed), 32'h0);
        chk("t6_num_async", 32'(playerNum), 32'h0);
        mark();
        run(2);
        reset = 0;
        mark();
        run(8);
        chk("t6_strobe_cycle", 32'(strobe_cyc), 32'd5);
        chk("t6_strobe_count", 32'(n_strobe), 32'd1);
        chk("t6_num", 32'(playerNum), 32'd2);
        btn = 0;
        run(5);

        // Randomised segments
        for (int s = 0; s < 120; s++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)      btn = 4'b0001 << $urandom_range(0, 3);
            else if (r < 75) btn = 4'($urandom_range(0, 15));
            else             btn = 4'b0000;
            if ($urandom_range(0, 9) == 0) simonTurn = !simonTurn;
            if (gameOver) gameOver = ($urandom_range(0, 2) != 0);
            else          gameOver = ($urandom_range(0, 19) == 0);
            for (int k = $urandom_range(1, 12); k > 0; k--) begin
                simonPressed = 1'($urandom_range(0, 1));
                simonNum = 2'($urandom_range(0, 3));
                step();
            end
        end
        btn = 0;
        gameOver = 0;
        run(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
